// File: rtl/uart_rx_packetizer.sv
// rtl/uart_rx_packetizer.sv - frames a UART byte stream (SYNC, LEN, payload) into a buffered output packet
// Optional trailing XOR check byte: define UART_RX_PACKETIZER_CHECKSUM_EN.
module uart_rx_packetizer #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_L    = 8'(MAX_LEN);

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_CHECK   = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
    CHECK,
`endif
    DRAIN
  } state_t;

  state_t state, next_state;

  logic [7:0]    len;
  logic [7:0]    wr_idx;
  logic [7:0]    rd_idx;
  logic [7:0]    rd_next;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    buffer [0:(2**AW)-1];
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic       timed;
  logic       tmo_hit;
  logic       err_fire;
  logic [1:0] err_cause;
  logic       wr_en;
  logic       enter_drain;
  logic       xfer;
  logic [7:0] first_byte;
  logic [7:0] next_byte;

  assign timed   = (state != IDLE) && (state != DRAIN);
  assign tmo_hit = timed && (tmo_cnt == TMO_LAST);
  assign xfer    = out_valid && out_ready;
  assign rd_next = rd_idx + 8'd1;

  // Without a check byte, DRAIN is entered on the edge that writes the last
  // payload byte, so a 1-byte packet must bypass the buffer.
  assign first_byte = (state == PAYLOAD && wr_idx == 8'd0) ? rx_data : buffer[0];
  assign next_byte  = buffer[rd_next[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    err_fire    = 1'b0;
    err_cause   = ERR_OVERRUN;
    wr_en       = 1'b0;
    enter_drain = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) next_state = LEN;
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MAX_L) begin
            err_fire   = 1'b1;
            err_cause  = ERR_LEN;
            next_state = IDLE;
          end else begin
            next_state = PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_fire   = 1'b1;
          err_cause  = ERR_TIMEOUT;
          next_state = IDLE;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          if (wr_idx == len - 8'd1) begin
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
            next_state = CHECK;
`else
            next_state  = DRAIN;
            enter_drain = 1'b1;
`endif
          end
        end else if (tmo_hit) begin
          err_fire   = 1'b1;
          err_cause  = ERR_TIMEOUT;
          next_state = IDLE;
        end
      end
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            next_state  = DRAIN;
            enter_drain = 1'b1;
          end else begin
            err_fire   = 1'b1;
            err_cause  = ERR_CHECK;
            next_state = IDLE;
          end
        end else if (tmo_hit) begin
          err_fire   = 1'b1;
          err_cause  = ERR_TIMEOUT;
          next_state = IDLE;
        end
      end
`endif
      DRAIN: begin
        if (rx_valid) begin
          err_fire  = 1'b1;
          err_cause = ERR_OVERRUN;
        end
        if (xfer && out_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Payload storage carries no reset: its contents are only read after a full frame.
  always_ff @(posedge clk) begin
    if (wr_en) buffer[wr_idx[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      err <= err_fire;
      if (err_fire) err_code <= err_cause;

      if (!timed || rx_valid) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + TW'(1);

      if (state == LEN && rx_valid) begin
        len    <= rx_data;
        wr_idx <= '0;
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
        csum   <= rx_data;
`endif
      end

      if (wr_en) begin
        wr_idx <= wr_idx + 8'd1;
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
        csum   <= csum ^ rx_data;
`endif
      end

      if (enter_drain) begin
        out_valid <= 1'b1;
        out_data  <= first_byte;
        out_last  <= (len == 8'd1);
        rd_idx    <= '0;
      end else if (xfer) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_data  <= '0;
        end else begin
          rd_idx   <= rd_next;
          out_data <= next_byte;
          out_last <= (rd_next == len - 8'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// tb/tb_uart_rx_packetizer.sv - directed bench with a queue-based frame model for uart_rx_packetizer
`timescale 1ns/1ps
module tb_uart_rx_packetizer;

  localparam int MAXL = 16;
  localparam int TMO  = 20;
`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, err;
  logic [7:0] out_data;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_packetizer #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .err      (err),
    .err_code (err_code)
  );

  function automatic logic [7:0] ck(input logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: mode 0 idle, 1 length, 2 payload, 3 check, 4 draining queue.
  int         m_mode = 0;
  int         m_len  = 0;
  int         m_gap  = 0;
  logic [7:0] m_pay[$];
  logic [7:0] m_dq[$];
  logic [7:0] m_x;
  logic       m_err  = 1'b0;
  logic [1:0] m_code = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_gap = 0; m_err = 1'b0; m_code = 2'd0;
      m_pay.delete(); m_dq.delete();
    end else begin
      m_err = 1'b0;
      if (m_mode == 0) begin
        if (rx_valid && rx_data == 8'hA5) begin m_mode = 1; m_gap = 0; end
      end else if (m_mode == 4) begin
        if (rx_valid) begin m_err = 1'b1; m_code = 2'd0; end
        if (out_ready) begin
          void'(m_dq.pop_front());
          if (m_dq.size() == 0) m_mode = 0;
        end
      end else if (rx_valid) begin
        m_gap = 0;
        if (m_mode == 1) begin
          if (rx_data == 8'd0 || rx_data > MAXL) begin
            m_err = 1'b1; m_code = 2'd2; m_mode = 0;
          end else begin
            m_len = rx_data; m_pay.delete(); m_mode = 2;
          end
        end else if (m_mode == 2) begin
          m_pay.push_back(rx_data);
          if (m_pay.size() == m_len) begin
            if (CK_EN) m_mode = 3;
            else begin m_dq = m_pay; m_mode = 4; end
          end
        end else begin
          m_x = m_len[7:0];
          foreach (m_pay[i]) m_x = m_x ^ m_pay[i];
          if (rx_data == m_x) begin m_dq = m_pay; m_mode = 4; end
          else begin m_err = 1'b1; m_code = 2'd1; m_mode = 0; end
        end
      end else begin
        m_gap++;
        if (m_gap == TMO) begin m_err = 1'b1; m_code = 2'd3; m_mode = 0; end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", out_valid, m_dq.size() > 0);
    if (m_dq.size() > 0) begin
      chk("out_data", out_data, m_dq[0]);
      chk("out_last", out_last, m_dq.size() == 1);
    end
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
  end

  logic [8:0] got[$];
  logic [1:0] elog[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back({out_last, out_data});
    if (!rst && err) elog.push_back(err_code);
  end

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic rxb(input logic [7:0] b);
    step(1'b1, b);
    step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b[$], input bit add_ck);
    rxb(8'hA5);
    foreach (b[i]) rxb(b[i]);
    if (add_ck && CK_EN) rxb(ck(b));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && out_valid; i++) step(1'b0, 8'h00);
    chk("drain_done", out_valid, 1'b0);
  endtask

  task automatic check_got(input string name, input logic [7:0] e[$]);
    bit ok;
    ok = (got.size() == e.size());
    if (ok) foreach (e[i]) if (got[i] !== {(i == e.size() - 1), e[i]}) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got {last,data} %p expected bytes %p (last on final)", name, got, e);
    end
    got.delete();
  endtask

  task automatic check_elog(input string name, input logic [1:0] e[$]);
    bit ok;
    ok = (elog.size() == e.size());
    if (ok) foreach (e[i]) if (elog[i] !== e[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got err codes %p expected %p", name, elog, e);
    end
    elog.delete();
  endtask

  logic [7:0] q[$];
  logic [7:0] e[$];
  logic [1:0] ec[$];
  logic [7:0] hold;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_outputs", {out_valid, out_data, out_last, err, err_code}, 13'h0);

    q = '{8'h02, 8'h10, 8'h20};
    chk("ck_pin_32", ck(q), 8'h32);
    q = '{8'h03, 8'h11, 8'h22, 8'h33};
    chk("ck_pin_03", ck(q), 8'h03);

    q = '{8'h03, 8'h11, 8'h22, 8'h33};
    send(q, 1'b1);
    wait_drain();
    e = '{8'h11, 8'h22, 8'h33};
    check_got("frame_a", e);
    ec = {};
    check_elog("frame_a_err", ec);

`ifdef UART_RX_PACKETIZER_CHECKSUM_EN
    q = '{8'h02, 8'h10, 8'h20, 8'h00};
    send(q, 1'b0);
    idle(2);
    e = {};
    check_got("bad_ck_out", e);
    ec = '{2'd1};
    check_elog("bad_ck_err", ec);
`else
    q = '{8'h02, 8'h10, 8'h20};
    send(q, 1'b1);
    wait_drain();
    e = '{8'h10, 8'h20};
    check_got("frame_b", e);
`endif
    q = '{8'h01, 8'h55};
    send(q, 1'b1);
    wait_drain();
    e = '{8'h55};
    check_got("frame_single", e);

    q = '{8'h00};
    send(q, 1'b0);
    q = '{8'h11};
    send(q, 1'b0);
    idle(2);
    ec = '{2'd2, 2'd2};
    check_elog("len_errs", ec);
    q = '{8'h01, 8'h66};
    send(q, 1'b1);
    wait_drain();
    e = '{8'h66};
    check_got("after_len_err", e);

    q = '{8'h02, 8'h7F};
    send(q, 1'b0);
    idle(TMO - 1);
    idle(2);
    ec = '{2'd3};
    check_elog("timeout", ec);
    q = '{8'h02, 8'h7F};
    send(q, 1'b0);
    idle(TMO - 2);
    rxb(8'h80);
    q = '{8'h02, 8'h7F, 8'h80};
    if (CK_EN) rxb(ck(q));
    wait_drain();
    e = '{8'h7F, 8'h80};
    check_got("expiry_byte", e);
    ec = {};
    check_elog("expiry_no_err", ec);

    out_ready = 1'b0;
    q = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    send(q, 1'b1);
    hold = out_data;
    chk("overrun_first", hold, 8'h01);
    idle(4);
    step(1'b1, 8'h99);
    idle(5);
    chk("overrun_hold", {out_valid, out_data}, {1'b1, hold});
    out_ready = 1'b1;
    wait_drain();
    e = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_got("overrun_bytes", e);
    ec = '{2'd0};
    check_elog("overrun_err", ec);

    rxb(8'hA5);
    rxb(8'h03);
    rxb(8'hAA);
    rxb(8'hBB);
    rst = 1'b1;
    #1;
    chk("rst_outputs", {out_valid, out_data, out_last, err, err_code}, 13'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);
    ec = {};
    check_elog("rst_no_err", ec);
    q = '{8'h01, 8'hC3};
    send(q, 1'b1);
    wait_drain();
    e = '{8'hC3};
    check_got("after_rst", e);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
